// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage that sits directly after the PC register.
//
// The stage fetches one word at the current PC from instruction memory over a
// valid/ready request channel. Responses come back in order with a variable
// latency and are always accepted. Returned words are buffered with their PCs
// in a small FIFO and passed to decode over valid/ready. The stage also drives
// the PC register load enable. On a redirect it discards fetches from the
// wrong path.
//
// The block holds a fixed pool of DEPTH slots. A slot is held by a live
// in-flight request (outstanding), by a wrong-path request whose response is
// still due (drop), or by a buffered instruction (FIFO). A new request is
// issued only while a slot is free. As a result the tag queue and the FIFO
// can never overflow, and drop never exceeds DEPTH.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_now            current PC from the PC register
//   pc_reg_en         PC register load enable (accepted request or redirect)
//   flush             redirect this cycle; all in-flight work is wrong-path
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_resp_*       in-order response channel (always accepted)
//   if_valid/if_ready decode handshake
//   if_inst/if_pc     FIFO head: instruction word and its PC
//   if_misalign       head entry is a misaligned-PC fault (if_inst = NOP_INST)

module ifetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_now,
  output logic            pc_reg_en,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            if_misalign
);

  localparam int        AW      = $clog2(DEPTH);
  localparam int        CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // Tag queue: the PC of every request that is still in flight, in issue order
  logic [XLEN-1:0]  tag_mem_r [DEPTH];
  logic [AW-1:0]    tag_wr_r;
  logic [AW-1:0]    tag_rd_r;

  // Output FIFO storage
  logic [XLEN-1:0]  fifo_pc_r   [DEPTH];
  logic [XLEN-1:0]  fifo_inst_r [DEPTH];
  logic [DEPTH-1:0] fifo_mis_r;
  logic [AW-1:0]    fifo_wr_r;
  logic [AW-1:0]    fifo_rd_r;
  logic [CW-1:0]    fifo_count_r;

  // Slot accounting
  logic [CW-1:0]    outstanding_r;
  logic [CW-1:0]    drop_r;
  logic             halted_r;

  logic [CW:0]      in_use_s;
  logic             may_issue_s;
  logic             misaligned_s;
  logic             req_valid_s;
  logic             req_fire_s;
  logic             fault_s;
  logic             resp_keep_s;
  logic             resp_drop_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic [XLEN-1:0]  push_pc_s;
  logic [XLEN-1:0]  push_inst_s;
  logic             push_mis_s;

  // Issue credit, request and handshake decode
  always_comb begin
    in_use_s     = {1'b0, outstanding_r} + {1'b0, drop_r} + {1'b0, fifo_count_r};
    may_issue_s  = !rst && !flush && !halted_r && (in_use_s < DEPTH_C);
    misaligned_s = (pc_now[1:0] != 2'b00);
    req_valid_s  = may_issue_s && !misaligned_s;
    req_fire_s   = req_valid_s && imem_req_ready;
    // A misaligned PC becomes a fault entry only after all older work has
    // drained, so that the fault stays in program order
    fault_s      = may_issue_s && misaligned_s &&
                   (outstanding_r == {CW{1'b0}}) && (drop_r == {CW{1'b0}});
    resp_keep_s  = imem_resp_valid && (drop_r == {CW{1'b0}});
    resp_drop_s  = imem_resp_valid && (drop_r != {CW{1'b0}});
    fifo_push_s  = !flush && (resp_keep_s || fault_s);
    fifo_pop_s   = !flush && (fifo_count_r != {CW{1'b0}}) && if_ready;
    if (resp_keep_s) begin
      push_pc_s   = tag_mem_r[tag_rd_r];
      push_inst_s = imem_resp_data;
      push_mis_s  = 1'b0;
    end else begin
      push_pc_s   = pc_now;
      push_inst_s = NOP_INST;
      push_mis_s  = 1'b1;
    end
  end

  // Output drive: request channel and FIFO head
  always_comb begin
    imem_req_valid = req_valid_s;
    imem_req_addr  = pc_now;
    pc_reg_en      = !rst && (req_fire_s || flush);
    if_valid       = (fifo_count_r != {CW{1'b0}});
    if_inst        = fifo_inst_r[fifo_rd_r];
    if_pc          = fifo_pc_r[fifo_rd_r];
    if_misalign    = fifo_mis_r[fifo_rd_r];
  end

  // Storage writes; contents are don't-care until the matching count says valid
  always_ff @(posedge clk) begin
    if (req_fire_s) begin
      tag_mem_r[tag_wr_r] <= pc_now;
    end
    if (fifo_push_s) begin
      fifo_pc_r[fifo_wr_r]   <= push_pc_s;
      fifo_inst_r[fifo_wr_r] <= push_inst_s;
      fifo_mis_r[fifo_wr_r]  <= push_mis_s;
    end
  end

  // Pointers, counters and the halt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_r      <= {AW{1'b0}};
      tag_rd_r      <= {AW{1'b0}};
      fifo_wr_r     <= {AW{1'b0}};
      fifo_rd_r     <= {AW{1'b0}};
      fifo_count_r  <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      drop_r        <= {CW{1'b0}};
      halted_r      <= 1'b0;
    end else begin
      if (req_fire_s) begin
        tag_wr_r <= tag_wr_r + AW'(1);
      end
      // Every response pops its tag, including discarded ones
      if (imem_resp_valid) begin
        tag_rd_r <= tag_rd_r + AW'(1);
      end
      if (flush) begin
        // Everything still in flight becomes wrong-path, except a response
        // that is landing right now
        fifo_wr_r     <= {AW{1'b0}};
        fifo_rd_r     <= {AW{1'b0}};
        fifo_count_r  <= {CW{1'b0}};
        outstanding_r <= {CW{1'b0}};
        drop_r        <= outstanding_r + drop_r - CW'(imem_resp_valid);
        halted_r      <= 1'b0;
      end else begin
        if (fifo_push_s) begin
          fifo_wr_r <= fifo_wr_r + AW'(1);
        end
        if (fifo_pop_s) begin
          fifo_rd_r <= fifo_rd_r + AW'(1);
        end
        fifo_count_r  <= fifo_count_r + CW'(fifo_push_s) - CW'(fifo_pop_s);
        outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(resp_keep_s);
        drop_r        <= drop_r - CW'(resp_drop_s);
        if (fault_s) begin
          halted_r <= 1'b1;
        end
      end
    end
  end

  ifetch_unit_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .fifo_push   (fifo_push_s),
    .fifo_pop    (fifo_pop_s),
    .fifo_count  (fifo_count_r),
    .resp_valid  (imem_resp_valid),
    .outstanding (outstanding_r),
    .drop        (drop_r)
  );

endmodule

// ifetch_unit_chk: invariants of the fetch stage's slot accounting.
//   fifo_push/fifo_pop/fifo_count  FIFO activity and occupancy
//   resp_valid                     memory response this cycle
//   outstanding/drop               live and wrong-path in-flight counts
module ifetch_unit_chk #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          fifo_push,
  input logic          fifo_pop,
  input logic [CW-1:0] fifo_count,
  input logic          resp_valid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] drop
);

  logic [CW:0] in_flight_s;
  assign in_flight_s = {1'b0, outstanding} + {1'b0, drop};

  // Sampled invariants: no FIFO overflow, no orphan response, drop bounded
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && !fifo_pop && (fifo_count == CW'(DEPTH))));
      assert (!(resp_valid && (in_flight_s == {(CW+1){1'b0}})));
      assert (drop <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a directed cycle table, hand sequences for the
// misalignment and mid-stream reset cases, then random traffic. A
// queue-based reference model checks every cycle. The bench plays the PC
// register and an in-order instruction memory with a variable latency.
module tb_ifetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, pc_reg_en;
  logic [31:0] pc_now;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        if_valid, if_ready, if_misalign;
  logic [31:0] if_inst, if_pc;

  ifetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_now(pc_now), .pc_reg_en(pc_reg_en), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;

  // Reference model state: in-flight requests, output buffer, halt flag
  typedef struct { logic [31:0] pc; bit wrong; } tag_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; bit mis; } ent_t;
  tag_t        inflight[$];
  ent_t        fq[$];
  bit          halted;
  logic [31:0] memq[$];    // memory side: addresses awaiting a response
  logic [31:0] pc;         // PC register

  int checks = 0;
  int errors = 0;

  bit          cur_rst, cur_flush, cur_ifr, cur_resp, cur_may, m_fire;
  logic [31:0] cur_tgt;

  typedef struct {
    bit r; bit fl; logic [31:0] tgt; bit rr; bit rsp; bit ifr;
    bit e_rv; logic [31:0] e_addr; bit e_en; bit e_iv; logic [31:0] e_pc;
  } row_t;
  row_t tbl[23];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic row_t mk(input bit r, input bit fl, input logic [31:0] tgt,
                              input bit rr, input bit rsp, input bit ifr,
                              input bit e_rv, input logic [31:0] e_addr,
                              input bit e_en, input bit e_iv, input logic [31:0] e_pc);
    row_t x;
    x.r = r; x.fl = fl; x.tgt = tgt; x.rr = rr; x.rsp = rsp; x.ifr = ifr;
    x.e_rv = e_rv; x.e_addr = e_addr; x.e_en = e_en; x.e_iv = e_iv; x.e_pc = e_pc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs (called at negedge) and check against the model
  task automatic drive(input bit r, input bit fl, input logic [31:0] tgt,
                       input bit rr, input bit rsp, input bit ifr);
    bit evalid;
    bit mr;
    mr = rsp && (memq.size() > 0);
    rst = r; flush = fl; imem_req_ready = rr; if_ready = ifr; pc_now = pc;
    imem_resp_valid = mr;
    imem_resp_data  = mr ? mem_word(memq[0]) : 32'h0;
    cur_rst = r; cur_flush = fl; cur_tgt = tgt; cur_ifr = ifr; cur_resp = mr;
    #1;
    cur_may = !r && !fl && !halted && ((inflight.size() + fq.size()) < DEPTH);
    evalid  = cur_may && (pc[1:0] == 2'b00);
    m_fire  = evalid && rr;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, evalid});
    if (evalid) chk("req_addr", imem_req_addr, pc);
    chk("pc_reg_en", {31'd0, pc_reg_en}, {31'd0, !r && (m_fire || fl)});
    if (!r) begin
      chk("if_valid", {31'd0, if_valid}, {31'd0, fq.size() > 0});
      if (fq.size() > 0) begin
        chk("if_pc", if_pc, fq[0].pc);
        chk("if_inst", if_inst, fq[0].inst);
        chk("if_misalign", {31'd0, if_misalign}, {31'd0, fq[0].mis});
      end
    end
  endtask

  // Advance the model by one cycle and wait for the next negedge
  task automatic advance();
    bit fault;
    tag_t t;
    logic [31:0] a;
    fault = cur_may && (pc[1:0] != 2'b00) && (inflight.size() == 0);
    if (cur_rst) begin
      inflight.delete(); fq.delete(); memq.delete(); halted = 1'b0; pc = 32'h0;
    end else if (cur_flush) begin
      fq.delete();
      foreach (inflight[i]) inflight[i].wrong = 1'b1;
      if (cur_resp) begin
        void'(inflight.pop_front());
        void'(memq.pop_front());
      end
      halted = 1'b0;
      pc = cur_tgt;
    end else begin
      if ((fq.size() > 0) && cur_ifr) void'(fq.pop_front());
      if (cur_resp) begin
        t = inflight.pop_front();
        a = memq.pop_front();
        if (!t.wrong) fq.push_back('{t.pc, mem_word(a), 1'b0});
      end
      if (m_fire) begin
        inflight.push_back('{pc, 1'b0});
        memq.push_back(pc);
        pc = pc + 32'd4;
      end
      if (fault) begin
        fq.push_back('{pc, NOP, 1'b1});
        halted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tgt;
    bit r, fl;
    rst = 1'b1; flush = 1'b0; pc_now = 32'h0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; if_ready = 1'b0;
    pc = 32'h0; halted = 1'b0;

    //              r  fl tgt         rr rsp ifr  rv addr        en iv pc
    tbl[0]  = mk(1, 0, 32'h0,      1, 0, 1,   0, 32'h0,   0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,      1, 0, 1,   1, 32'h0,   1, 0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,      1, 1, 1,   1, 32'h4,   1, 0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,      1, 1, 1,   0, 32'h0,   0, 1, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,      1, 0, 1,   1, 32'h8,   1, 1, 32'h4);
    tbl[5]  = mk(0, 0, 32'h0,      1, 1, 1,   1, 32'hC,   1, 0, 32'h0);
    tbl[6]  = mk(0, 0, 32'h0,      1, 1, 0,   0, 32'h0,   0, 1, 32'h8);
    tbl[7]  = mk(0, 0, 32'h0,      1, 0, 0,   0, 32'h0,   0, 1, 32'h8);
    tbl[8]  = mk(0, 0, 32'h0,      1, 0, 1,   0, 32'h0,   0, 1, 32'h8);
    tbl[9]  = mk(0, 0, 32'h0,      1, 0, 1,   1, 32'h10,  1, 1, 32'hC);
    tbl[10] = mk(0, 0, 32'h0,      0, 1, 1,   1, 32'h14,  0, 0, 32'h0);
    tbl[11] = mk(0, 0, 32'h0,      0, 0, 0,   1, 32'h14,  0, 1, 32'h10);
    tbl[12] = mk(0, 0, 32'h0,      0, 0, 0,   1, 32'h14,  0, 1, 32'h10);
    tbl[13] = mk(0, 0, 32'h0,      1, 0, 0,   1, 32'h14,  1, 1, 32'h10);
    tbl[14] = mk(0, 0, 32'h0,      1, 1, 1,   0, 32'h0,   0, 1, 32'h10);
    tbl[15] = mk(0, 1, 32'h40,     1, 0, 1,   0, 32'h0,   1, 1, 32'h14);
    tbl[16] = mk(0, 0, 32'h0,      1, 0, 1,   1, 32'h40,  1, 0, 32'h0);
    tbl[17] = mk(0, 0, 32'h0,      1, 0, 1,   1, 32'h44,  1, 0, 32'h0);
    tbl[18] = mk(0, 1, 32'h80,     1, 0, 1,   0, 32'h0,   1, 0, 32'h0);
    tbl[19] = mk(0, 0, 32'h0,      1, 1, 1,   0, 32'h0,   0, 0, 32'h0);
    tbl[20] = mk(0, 0, 32'h0,      1, 1, 1,   1, 32'h80,  1, 0, 32'h0);
    tbl[21] = mk(0, 0, 32'h0,      1, 1, 1,   1, 32'h84,  1, 0, 32'h0);
    tbl[22] = mk(0, 0, 32'h0,      0, 0, 1,   0, 32'h0,   0, 1, 32'h80);

    @(negedge clk);
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].r, tbl[i].fl, tbl[i].tgt, tbl[i].rr, tbl[i].rsp, tbl[i].ifr);
      if (!tbl[i].r) begin
        chk("tbl_req_valid", {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rv});
        if (tbl[i].e_rv) chk("tbl_req_addr", imem_req_addr, tbl[i].e_addr);
        chk("tbl_pc_reg_en", {31'd0, pc_reg_en}, {31'd0, tbl[i].e_en});
        chk("tbl_if_valid", {31'd0, if_valid}, {31'd0, tbl[i].e_iv});
        if (tbl[i].e_iv) begin
          chk("tbl_if_pc", if_pc, tbl[i].e_pc);
          chk("tbl_if_inst", if_inst, mem_word(tbl[i].e_pc));
        end
      end
      advance();
    end

    // Redirect to a misaligned target: drain, emit the fault, then stay halted
    drive(0, 1, 32'h42, 1, 0, 0); advance();
    drive(0, 0, 32'h0, 1, 1, 0);  advance();
    drive(0, 0, 32'h0, 1, 0, 0);  advance();
    drive(0, 0, 32'h0, 1, 0, 0);
    chk("mis_if_valid", {31'd0, if_valid}, 32'd1);
    chk("mis_if_pc", if_pc, 32'h42);
    chk("mis_if_inst", if_inst, 32'h0000_0013);
    chk("mis_flag", {31'd0, if_misalign}, 32'd1);
    chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    advance();
    drive(0, 0, 32'h0, 1, 0, 1);  advance();
    drive(0, 0, 32'h0, 1, 0, 1);
    chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("halt_no_pc_en", {31'd0, pc_reg_en}, 32'd0);
    advance();
    drive(0, 1, 32'h100, 1, 0, 1); advance();
    drive(0, 0, 32'h0, 1, 0, 1);
    chk("resume_req", {31'd0, imem_req_valid}, 32'd1);
    chk("resume_addr", imem_req_addr, 32'h100);
    advance();

    // Reset in the middle of traffic
    drive(0, 0, 32'h0, 1, 1, 0); advance();
    drive(0, 0, 32'h0, 1, 1, 0); advance();
    drive(1, 0, 32'h0, 1, 0, 0); advance();
    drive(1, 0, 32'h0, 1, 0, 0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_pc_en", {31'd0, pc_reg_en}, 32'd0);
    advance();
    drive(0, 0, 32'h0, 1, 0, 1);
    chk("post_rst_addr", imem_req_addr, 32'h0);
    advance();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 32'd0);
      fl  = !r && ($urandom_range(0, 15) == 32'd0);
      tgt = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 3) == 32'd0) tgt[1:0] = 2'($urandom_range(1, 3));
      drive(r, fl, tgt, $urandom_range(0, 3) != 32'd0, $urandom_range(0, 1) != 32'd0,
            $urandom_range(0, 2) != 32'd0);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
